// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Default geometry plus a constant log2 used for pointer and count widths.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_DATA_DEPTH = 128;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int fifo_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: one synchronous write port and one
// registered read port. No reset; contents are undefined until written.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk_sys,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and count-based full/empty.
// Optional macro SYNC_FIFO_COUNT_EN exposes the occupancy on o_count.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DATA_DEPTH = DEFAULT_DATA_DEPTH
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_wren,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rden,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty
`ifdef SYNC_FIFO_COUNT_EN
    ,
    output logic [fifo_log2(DATA_DEPTH):0] o_count
`endif
);

    localparam int ADDR_W = fifo_log2(DATA_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0]     wr_ptr_q;
    logic [ADDR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  full;
    logic                  empty;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full  = (count_q == CNT_W'(DATA_DEPTH));
    assign empty = (count_q == '0);

    // Full/empty gating alone resolves the simultaneous cases: read wins when
    // full, write wins when empty (no fall-through).
    assign wr_ok = i_wren && !full;
    assign rd_ok = i_rden && !empty;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
                rd_valid_q <= 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_W)
    ) u_ram (
        .clk_sys (i_sys_clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (i_wdata),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

    // The RAM output register has no reset; mask it until a read lands after reset.
    assign o_rdata = rd_valid_q ? ram_rdata : '0;
    assign o_full  = full;
    assign o_empty = empty;

`ifdef SYNC_FIFO_COUNT_EN
    assign o_count = count_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (default 16 x 128 geometry).
// Checks o_count as well when SYNC_FIFO_COUNT_EN is defined.
module tb_sync_fifo;

    logic        clk;
    logic        rst;
    logic        wren;
    logic [15:0] wdata;
    logic        rden;
    logic [15:0] rdata;
    logic        full;
    logic        empty;
`ifdef SYNC_FIFO_COUNT_EN
    logic [7:0]  count;
`endif

    int checks = 0;
    int errors = 0;

    sync_fifo #(
        .DATA_WIDTH (16),
        .DATA_DEPTH (128)
    ) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .i_wren    (wren),
        .i_wdata   (wdata),
        .i_rden    (rden),
        .o_rdata   (rdata),
        .o_full    (full),
        .o_empty   (empty)
`ifdef SYNC_FIFO_COUNT_EN
        ,
        .o_count   (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_count(input string tag, input int exp);
`ifdef SYNC_FIFO_COUNT_EN
        check(tag, 32'(count), 32'(exp));
`endif
    endtask

    // Drive one cycle of requests; returns 1 time unit after the rising edge.
    task automatic step(input logic wr, input logic [15:0] wd, input logic rd);
        wren  = wr;
        wdata = wd;
        rden  = rd;
        @(posedge clk);
        #1;
        wren = 1'b0;
        rden = 1'b0;
    endtask

    logic [15:0] order_vec [10] = '{16'h0024, 16'h0081, 16'h0009, 16'h0063, 16'h000D,
                                    16'h008D, 16'h0065, 16'h0012, 16'h0001, 16'h000D};

    initial begin
        rst   = 1'b1;
        wren  = 1'b0;
        rden  = 1'b0;
        wdata = '0;
        @(posedge clk);
        #1;
        step(1'b0, 16'h0, 1'b0);
        rst = 1'b0;

        // Reset state and read on empty
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check_count("rst_count", 0);
        step(1'b0, 16'h0, 1'b1);
        check("empty_rd_rdata", 32'(rdata), 32'd0);
        check("empty_rd_empty", 32'(empty), 32'd1);

        // Basic FIFO order
        for (int i = 0; i < 10; i++) step(1'b1, order_vec[i], 1'b0);
        check("order_not_empty", 32'(empty), 32'd0);
        check_count("order_count10", 10);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h0, 1'b1);
            check($sformatf("order_rd%0d", i), 32'(rdata), 32'(order_vec[i]));
        end
        check("order_empty", 32'(empty), 32'd1);
        check_count("order_count0", 0);
        step(1'b0, 16'h0, 1'b0);
        check("order_hold", 32'(rdata), 32'h000D);

        // Full boundary
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 16'(i), 1'b0);
            if (i == 126) check("full_at127", 32'(full), 32'd0);
        end
        check("full_at128", 32'(full), 32'd1);
        check_count("full_count", 128);
        step(1'b1, 16'hFFFF, 1'b0);
        check("full_drop_full", 32'(full), 32'd1);
        check("full_drop_rdata", 32'(rdata), 32'h000D);
        check_count("full_drop_count", 128);
        // Both requests while full: read taken, write refused
        step(1'b1, 16'hFFFF, 1'b1);
        check("full_both_rdata", 32'(rdata), 32'd0);
        check("full_both_full", 32'(full), 32'd0);
        check_count("full_both_count", 127);
        for (int i = 1; i < 128; i++) begin
            step(1'b0, 16'h0, 1'b1);
            check($sformatf("full_rd%0d", i), 32'(rdata), 32'(i));
        end
        check("full_drained", 32'(empty), 32'd1);

        // Move pointers near the wrap point
        for (int i = 0; i < 115; i++) begin
            step(1'b1, 16'(16'h0200 + i), 1'b0);
            step(1'b0, 16'h0, 1'b1);
            if (i == 114) check("adv_rdata", 32'(rdata), 32'h0272);
        end

        // Simultaneous read/write with 5 stored, crossing the wrap
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'(16'h0105 + i), 1'b1);
            check($sformatf("sim_rd%0d", i), 32'(rdata), 32'(16'h0100 + i));
            check_count("sim_count", 5);
        end
        check("sim_empty", 32'(empty), 32'd0);
        check("sim_full", 32'(full), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 16'h0, 1'b1);
            check($sformatf("sim_drain%0d", i), 32'(rdata), 32'(16'h0114 + i));
        end
        check("sim_drained", 32'(empty), 32'd1);

        // Both requests while empty: write taken, no fall-through
        step(1'b1, 16'h0055, 1'b1);
        check("empty_both_rdata", 32'(rdata), 32'h0118);
        check("empty_both_empty", 32'(empty), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        check("empty_both_rd", 32'(rdata), 32'h0055);

        // Mid-operation reset
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0300 + i), 1'b0);
        rst = 1'b1;
        step(1'b1, 16'h1234, 1'b1);
        rst = 1'b0;
        check("mrst_empty", 32'(empty), 32'd1);
        check("mrst_full", 32'(full), 32'd0);
        check("mrst_rdata", 32'(rdata), 32'd0);
        check_count("mrst_count", 0);
        step(1'b1, 16'hA5A5, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        check("mrst_rd", 32'(rdata), 32'hA5A5);
        check("mrst_empty2", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bits per word.
REQ-002 SHALL have parameter DATA_DEPTH, default 128, number of storage words; must be a power of two and at least 2.
REQ-003 SHALL have port i_sys_clk, input, 1 bit; the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_sys_rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port i_wren, input, 1 bit; write request.
REQ-006 SHALL have port i_wdata, input, DATA_WIDTH bits; write data, sampled with i_wren.
REQ-007 SHALL have port i_rden, input, 1 bit; read request.
REQ-008 SHALL have port o_rdata, output, DATA_WIDTH bits; registered read data.
REQ-009 SHALL have port o_full, output, 1 bit; high when DATA_DEPTH words are stored.
REQ-010 SHALL have port o_empty, output, 1 bit; high when 0 words are stored.

Function
REQ-011 SHALL store words first-in first-out, with capacity exactly DATA_DEPTH.
REQ-012 SHALL accept a write on a rising edge when i_wren=1 and o_full=0; the word is stored at the write pointer and the pointer increments.
REQ-013 SHALL accept a read on a rising edge when i_rden=1 and o_empty=0; the oldest word appears on o_rdata after that same edge (1-cycle latency), and the read pointer increments.
REQ-014 SHALL ignore a write while o_full=1: no storage change, no pointer change, no error output.
REQ-015 SHALL ignore a read while o_empty=1: o_rdata holds its last value and pointers are unchanged.
REQ-016 SHALL hold o_rdata stable in every cycle without an accepted read.
REQ-017 SHALL process an accepted read and an accepted write in the same cycle with the occupancy unchanged.
- When full with both requests: read accepted, write rejected.
- When empty with both requests: write accepted, read rejected; there is no fall-through.
REQ-018 SHALL wrap the pointers modulo DATA_DEPTH; full/empty detection SHALL use an occupancy count of width log2(DATA_DEPTH)+1, or pointers with one extra wrap bit.
REQ-019 SHALL derive o_full and o_empty from registered state, so that they are valid in the cycle after the edge that changed occupancy.

Reset
REQ-020 SHALL, on a rising edge with i_sys_rst=1, clear both pointers and the occupancy to 0, set o_empty=1, o_full=0 and o_rdata=0.
REQ-021 SHALL discard any stored words on reset, including a reset asserted mid-operation; memory contents need not be cleared.
REQ-022 SHALL give reset priority over i_wren and i_rden in the same cycle.

Configuration
REQ-023 SHALL, when macro SYNC_FIFO_COUNT_EN is defined, add output o_count of width log2(DATA_DEPTH)+1 holding the current occupancy (0..DATA_DEPTH), registered and reset to 0.
REQ-024 SHALL, when SYNC_FIFO_COUNT_EN is undefined, omit the o_count port entirely while keeping all other behaviour identical.

Structure
REQ-025 SHALL place the default DATA_WIDTH/DATA_DEPTH constants and an address-width helper function (log2) in shared package sync_fifo_pkg.
REQ-026 SHALL implement storage in one sub-module, sync_fifo_ram: a simple dual-port RAM with one synchronous write port, one synchronous registered read port and no reset. Pointer and flag logic stays in sync_fifo.

Verification
REQ-027 Reset check: after reset, o_empty=1, o_full=0, o_rdata=0; a read on empty leaves o_rdata=0 and o_empty=1.
REQ-028 Basic order: write 10 words 0x0024,0x0081,0x0009,0x0063,0x000D,0x008D,0x0065,0x0012,0x0001,0x000D on consecutive cycles, then read 10 times. o_rdata returns the same sequence, 1 cycle after each read edge, and o_empty=1 after the 10th read.
REQ-029 Full boundary: write 128 words 0..127. o_full=1 after the 128th; a 129th write of 0xFFFF is dropped; 128 reads return 0..127 in order.
REQ-030 Simultaneous access: with 5 words stored, assert i_wren and i_rden for 20 cycles. Occupancy stays 5 and read data stays in order across the pointer wrap.
REQ-031 Mid-operation reset: write 3 words, pulse i_sys_rst for 1 cycle. o_empty=1 and o_rdata=0; subsequent writes of 0xA5A5 then a read return 0xA5A5.
REQ-032 With SYNC_FIFO_COUNT_EN defined, o_count tracks 0->10->0 during the REQ-028 sequence and reads 128 when full.
